// File: rtl/fv_bank_cntl.sv
// Per-bank FV responder: accepts one vector request, reads NUM_BEATS SRAM words
// and streams them to the PE side through a 2-entry buffer with valid/ready.
module fv_bank_cntl #(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NUM_BEATS = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req_valid,
    input  logic [TAG_W-1:0]                      req_PE_tag,
    input  logic [ADDR_W-1:0]                     req_FV_Bank_addr,
    output logic                                  Bank_busy,
    output logic                                  sram_rd_en,
    output logic [ADDR_W+$clog2(NUM_BEATS)-1:0]   sram_addr,
    input  logic [DATA_W-1:0]                     sram_rdata,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_W-1:0]                     out_data,
    output logic [TAG_W-1:0]                      out_PE_tag,
    output logic                                  out_last,
    output logic                                  proto_err
);

    localparam int unsigned BEAT_W = $clog2(NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic                busy_q;
    logic                err_q;
    logic [TAG_W-1:0]    tag_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BEAT_W-1:0]   issue_cnt;
    logic [BEAT_W-1:0]   ret_cnt;
    logic                rdv;
    logic [DATA_W-1:0]   buf_data [2];
    logic                buf_last [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;

    logic                pop;
    logic                credit_ok;

    // Buffer head drives the PE-side beat; the tag belongs to the vector in flight.
    assign out_valid  = (count != 2'd0);
    assign out_data   = buf_data[rd_ptr];
    assign out_last   = buf_last[rd_ptr];
    assign out_PE_tag = tag_q;
    assign pop        = out_valid & out_ready;

    // A read issued now lands in the buffer next cycle; what will already be held
    // at the end of this cycle must leave room for it.
    assign credit_ok  = ((3'(count) + 3'(rdv)) <= (3'd1 + 3'(pop)));
    assign sram_rd_en = (state == READ) && credit_ok;
    assign sram_addr  = {addr_q, issue_cnt};

    assign Bank_busy  = busy_q;
    assign proto_err  = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            tag_q     <= '0;
            addr_q    <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            rdv       <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            rdv <= sram_rd_en;

            if (sram_rd_en) begin
                issue_cnt <= issue_cnt + BEAT_W'(1);
            end

            // Returning word enters the buffer tagged with its beat position.
            if (rdv) begin
                buf_data[wr_ptr] <= sram_rdata;
                buf_last[wr_ptr] <= (ret_cnt == LAST_BEAT);
                wr_ptr           <= ~wr_ptr;
                ret_cnt          <= ret_cnt + BEAT_W'(1);
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            count <= count + 2'(rdv) - 2'(pop);

            if (req_valid && busy_q) begin
                err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tag_q     <= req_PE_tag;
                        addr_q    <= req_FV_Bank_addr;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        busy_q    <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (sram_rd_en && (issue_cnt == LAST_BEAT)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fv_bank_cntl.sv
// Scoreboard bench for fv_bank_cntl: an SRAM model supplies data, expected beats
// are queued at request time and compared as the DUT hands beats off.
module tb_fv_bank_cntl;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned NUM_BEATS = 4;
    localparam int unsigned SA_W      = ADDR_W + 2;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic [TAG_W-1:0]  req_PE_tag;
    logic [ADDR_W-1:0] req_FV_Bank_addr;
    logic              Bank_busy;
    logic              sram_rd_en;
    logic [SA_W-1:0]   sram_addr;
    logic [DATA_W-1:0] sram_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_PE_tag;
    logic              out_last;
    logic              proto_err;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              last;
    } beat_t;

    beat_t             sb [$];
    logic [DATA_W-1:0] mem [1 << SA_W];
    int                errors = 0;
    int                checks = 0;
    int                outstanding = 0;
    int                rd_total = 0;
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;

    fv_bank_cntl #(
        .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_BEATS(NUM_BEATS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_PE_tag(req_PE_tag),
        .req_FV_Bank_addr(req_FV_Bank_addr),
        .Bank_busy(Bank_busy),
        .sram_rd_en(sram_rd_en),
        .sram_addr(sram_addr),
        .sram_rdata(sram_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_PE_tag(out_PE_tag),
        .out_last(out_last),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (sram_rd_en) sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: compare every handshake, track buffer+inflight occupancy.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            outstanding = 0;
            prev_stall  = 0;
        end else begin
            check("overflow", 64'(outstanding > 2), 64'd0);
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_tag", 64'(out_PE_tag), 64'(e.tag));
                    check("beat_last", 64'(out_last), 64'(e.last));
                end
            end
            outstanding += int'(sram_rd_en) - int'(out_valid && out_ready);
            rd_total    += int'(sram_rd_en);
            prev_stall   = out_valid && !out_ready;
            prev_data    = out_data;
        end
    end

    // Drive a one-cycle request; queue its beats only when it should be accepted.
    task automatic send_req(input logic [TAG_W-1:0] tag, input logic [ADDR_W-1:0] addr,
                            input bit legal);
        req_valid        = 1'b1;
        req_PE_tag       = tag;
        req_FV_Bank_addr = addr;
        if (legal) begin
            for (int k = 0; k < NUM_BEATS; k++) begin
                beat_t b;
                logic [SA_W-1:0] idx;
                idx    = {addr, 2'(k)};
                b.data = mem[idx];
                b.tag  = tag;
                b.last = (k == NUM_BEATS - 1);
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (Bank_busy && n < 400) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (n >= 400) check("drain_timeout", 64'd1, 64'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        int rd_snap;
        for (int i = 0; i < (1 << SA_W); i++) mem[i] = {$urandom, $urandom};
        reset            = 1'b0;
        req_valid        = 1'b0;
        req_PE_tag       = '0;
        req_FV_Bank_addr = '0;
        out_ready        = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(Bank_busy), 64'd0);
        check("rst_rd_en", 64'(sram_rd_en), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_tag", 64'(out_PE_tag), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_err", 64'(proto_err), 64'd0);
        reset = 1'b1;

        // Cycle-exact single request, tag 5 addr 2
        @(posedge clk);
        #1;
        send_req(4'd5, 2'd2, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("t1_busy_c%0d", c), 64'(Bank_busy), 64'(c <= 6));
            check($sformatf("t1_rd_c%0d", c), 64'(sram_rd_en), 64'(c <= 4));
            if (c <= 4) check($sformatf("t1_addr_c%0d", c), 64'(sram_addr), 64'(8 + c - 1));
            check($sformatf("t1_valid_c%0d", c), 64'(out_valid), 64'(c >= 3 && c <= 6));
            check($sformatf("t1_last_c%0d", c), 64'(out_last), 64'(c == 6));
        end

        // Back-to-back: new request in the first cycle busy reads low
        send_req(4'd7, 2'd1, 1'b1);
        drain(1'b0);
        send_req(4'd3, 2'd3, 1'b1);
        @(negedge clk);
        check("b2b_rd_en", 64'(sram_rd_en), 64'd1);
        check("b2b_addr", 64'(sram_addr), 64'd12);
        check("b2b_busy", 64'(Bank_busy), 64'd1);
        drain(1'b0);

        // Backpressure from T+3 for 5 cycles
        rd_snap = rd_total;
        send_req(4'd10, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain(1'b0);
        @(negedge clk);
        check("bp_reads", 64'(rd_total - rd_snap), 64'd4);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Illegal request during READ
        check("err_before", 64'(proto_err), 64'd0);
        send_req(4'd3, 2'd1, 1'b1);
        send_req(4'd9, 2'd2, 1'b0);
        drain(1'b0);
        check("err_set", 64'(proto_err), 64'd1);
        send_req(4'd6, 2'd0, 1'b1);
        drain(1'b0);
        check("err_sticky", 64'(proto_err), 64'd1);

        // Random backpressure, random tags and addresses
        for (int r = 0; r < 100; r++) begin
            send_req(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1);
            drain(1'b1);
        end
        check("rand_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during beat 2 of a vector
        send_req(4'd12, 2'd3, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_busy", 64'(Bank_busy), 64'd0);
        check("mid_rst_rd_en", 64'(sram_rd_en), 64'd0);
        check("mid_rst_addr", 64'(sram_addr), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_tag", 64'(out_PE_tag), 64'd0);
        check("mid_rst_last", 64'(out_last), 64'd0);
        check("mid_rst_err", 64'(proto_err), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_req(4'd2, 2'd1, 1'b1);
        drain(1'b0);
        @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fv_bank_cntl.md
# fv_bank_cntl

Per-bank responder for the FV memory controller's routing interface: accepts one feature-vector read request (valid, PE tag, bank-local address) from the FV memory controller and holds Bank_busy high for the duration. Reads the vector from its SRAM bank as NUM_BEATS consecutive words and streams them to the PE-side output with valid/ready backpressure, tagging each beat with the requesting PE. One instance per FV bank, Num_Banks_FV instances total.

## Interface
- ADDR_W, 2: bank-local FV address width (FV_Bank_addr).
- TAG_W, 4: PE_tag width.
- DATA_W, 64: SRAM word / output beat width.
- NUM_BEATS, 4: words per feature vector; power of two, ≥2. BEAT_W = log2(NUM_BEATS).

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request strobe from the FV memory controller (one cycle per request).
- req_PE_tag  in  TAG_W  requesting PE.
- req_FV_Bank_addr  in  ADDR_W  vector index within this bank.
- Bank_busy  out  1  registered; high from the cycle after acceptance until the cycle after the last beat handshake.
- sram_rd_en  out  1  SRAM read strobe; data returns exactly 1 cycle later.
- sram_addr  out  ADDR_W+BEAT_W  {FV_Bank_addr, beat index}.
- sram_rdata  in  DATA_W  SRAM read data.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_W  beat payload.
- out_PE_tag  out  TAG_W  tag of current vector.
- out_last  out  1  high on final beat (beat NUM_BEATS-1).
- proto_err  out  1  sticky; set when req_valid arrives while Bank_busy=1.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: Bank_busy=0. req_valid=1 → latch tag and address, clear issue/return beat counters, → READ.
- READ: issue reads for beats 0..NUM_BEATS-1 in order, subject to credit; after the last read issues → DRAIN.
- DRAIN: wait for all beats to be handed off; handshake on beat NUM_BEATS-1 (out_valid & out_ready & out_last) → IDLE.
- Output buffer: 2-entry FIFO written by the returning sram_rdata, popped on out_valid & out_ready. out_data/out_PE_tag/out_last are driven from the buffer head; out_valid = buffer non-empty.
- Credit rule: issue in a cycle only if count + inflight − pop ≤ 1. Here count is the buffer occupancy, inflight is the read issued last cycle, and pop is the handshake this cycle. The buffer can never overflow; sustained throughput is 1 beat/cycle with out_ready held high.
- out_last is computed from the return counter at buffer write; a beat index wraps only via the counter reset in IDLE.
- req_valid while Bank_busy=1: request ignored (no state change, latched tag/address unchanged), proto_err set until reset.
- out_ready low: reads stall once the buffer plus inflight reaches 2. No beat may be dropped, duplicated or reordered, and head data stays stable while out_valid & !out_ready.
- Reset (any state, including mid-vector): state=IDLE, buffer emptied, counters cleared, inflight return discarded. Outputs: Bank_busy=0, sram_rd_en=0, sram_addr=0, out_valid=0, out_data=0, out_PE_tag=0, out_last=0, proto_err=0.

## Timing
- Request sampled at the edge ending cycle T.
  - T+1: Bank_busy=1, sram_rd_en=1, sram_addr={addr,0}.
  - T+2: sram_rdata beat 0 valid; written to buffer at end of T+2.
  - T+3: out_valid=1 with beat 0.
- With out_ready=1 throughout, beat k is output in cycle T+3+k, and out_last is in cycle T+2+NUM_BEATS.
- Bank_busy falls in the cycle after the last handshake; a new req_valid is accepted in that same cycle (zero-bubble turnaround, busy pulses low one cycle).
- Bank_busy is never combinationally dependent on req_valid.

## Test plan
- Single request, out_ready=1, tag=5, addr=2, NUM_BEATS=4:
  - sram_addr 8,9,10,11 in cycles T+1..T+4;
  - out beats T+3..T+6, out_last only at T+6, out_PE_tag=5 each beat;
  - Bank_busy high T+1..T+6, low T+7.
- Backpressure: out_ready=0 from T+3 for 5 cycles:
  - at most 2 reads outstanding (buffer + inflight);
  - out_data stable while stalled;
  - all 4 beats delivered in order after release; no sram_rd_en beyond 4 total.
- Random out_ready (50%) over 100 requests with random tags/addresses: scoreboard exact data/tag/last sequence against an SRAM model, no overflow.
- Back-to-back requests: second req_valid in the cycle Bank_busy first reads 0 → accepted; its first sram_rd_en occurs in the next cycle.
- Illegal request: req_valid during READ with tag=9 → ignored, current vector completes with original tag, proto_err=1 and stays 1.
- Reset asserted during beat 2 of a vector: next cycle all outputs 0, state IDLE; a fresh request then completes normally with beats starting at beat 0.
